// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
//   Serializes single-cycle button press pulses onto one valid/ready event
//   stream. One pending flag per button, round-robin grant, registered output.
//   Presses that arrive while the same button is still queued are coalesced
//   and raise a sticky overflow flag.
//
//   Optional build macro BTN_ARB_OVF_CNT_EN adds an 8-bit saturating count of
//   coalesced presses (port ovf_cnt). Without it the port and counter are absent.

// Per-button pending flag. A press in the same cycle as this button's grant
// re-arms the flag; a press while the flag is held and not granted is lost.
module btn_arb_lane (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    input  logic gnt,
    output logic pend,
    output logic coal
);
    assign coal = pulse & pend & ~gnt;

    // pending flag: set by a press, cleared by a grant, press wins on a tie
    always_ff @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= pulse | (pend & ~gnt);
    end
endmodule

module btn_event_arbiter #(
    parameter int N_BTN = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic [N_BTN-1:0] pending,
    output logic             overflow,
    input  logic             ovf_clr
`ifdef BTN_ARB_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   rr_next;
    logic               found;
    logic               slot_free;
    logic               load;
    logic [N_BTN-1:0]   gnt;
    logic [N_BTN-1:0]   coal;
    logic [2*N_BTN-1:0] pend_rot;
    logic [IDX_W:0]     pos;

    assign slot_free = !evt_valid || evt_ready;
    assign load      = slot_free && (|pending);

    // Round-robin search: rotate the doubled pending vector so bit 0 is the
    // button at rr_ptr, then take the first set bit. Position wraps at N_BTN.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        pos      = '0;
        pend_rot = {pending, pending} >> rr_ptr;
        for (int k = 0; k < N_BTN; k++) begin
            if (!found && pend_rot[0]) begin
                found = 1'b1;
                pos   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (pos >= (IDX_W+1)'(N_BTN))
                    pos = pos - (IDX_W+1)'(N_BTN);
                win   = pos[IDX_W-1:0];
            end
            pend_rot = pend_rot >> 1;
        end
    end

    assign rr_next = (win == IDX_W'(N_BTN-1)) ? '0 : win + 1'b1;
    assign gnt     = load ? (N_BTN'(1) << win) : '0;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        btn_arb_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .pulse (btn_pulse[i]),
            .gnt   (gnt[i]),
            .pend  (pending[i]),
            .coal  (coal[i])
        );
    end

    // output slot and pointer: load the winner whenever the slot frees up
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            rr_ptr    <= '0;
        end else if (slot_free) begin
            evt_valid <= |pending;
            if (|pending) begin
                evt_idx <= win;
                rr_ptr  <= rr_next;
            end
        end
    end

    // sticky overflow; a new coalesced press beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst)          overflow <= 1'b0;
        else if (|coal)   overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

`ifdef BTN_ARB_OVF_CNT_EN
    logic [4:0]       coal_cnt;
    logic [N_BTN-1:0] coal_sh;
    logic [8:0]       cnt_sum;

    // popcount of presses lost this cycle, added to a cleared or held base
    always_comb begin
        coal_cnt = '0;
        coal_sh  = coal;
        for (int k = 0; k < N_BTN; k++) begin
            coal_cnt = coal_cnt + 5'(coal_sh[0]);
            coal_sh  = coal_sh >> 1;
        end
        cnt_sum = (ovf_clr ? 9'd0 : {1'b0, ovf_cnt}) + 9'(coal_cnt);
    end

    // saturating coalesced-press counter
    always_ff @(posedge clk) begin
        if (rst)               ovf_cnt <= '0;
        else if (cnt_sum[8])   ovf_cnt <= 8'hff;
        else                   ovf_cnt <= cnt_sum[7:0];
    end
`endif
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter: a 4-button and a 3-button
// instance, directed scenarios followed by randomized traffic, all compared
// cycle by cycle against a queue-level reference model.
module tb_btn_event_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, rdy4 = 1'b1, clr4 = 1'b0, v4, ovf4;
    logic [3:0] pulse4 = '0, pend4;
    logic [1:0] idx4;
    logic       rst3 = 1'b1, rdy3 = 1'b1, clr3 = 1'b0, v3, ovf3;
    logic [2:0] pulse3 = '0, pend3;
    logic [1:0] idx3;
`ifdef BTN_ARB_OVF_CNT_EN
    logic [7:0] cnt4, cnt3;
`endif

    btn_event_arbiter #(.N_BTN(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst(rst4), .btn_pulse(pulse4), .evt_valid(v4),
        .evt_ready(rdy4), .evt_idx(idx4), .pending(pend4),
        .overflow(ovf4), .ovf_clr(clr4)
`ifdef BTN_ARB_OVF_CNT_EN
        , .ovf_cnt(cnt4)
`endif
    );

    btn_event_arbiter #(.N_BTN(3), .IDX_W(2)) dut3 (
        .clk(clk), .rst(rst3), .btn_pulse(pulse3), .evt_valid(v3),
        .evt_ready(rdy3), .evt_idx(idx3), .pending(pend3),
        .overflow(ovf3), .ovf_clr(clr3)
`ifdef BTN_ARB_OVF_CNT_EN
        , .ovf_cnt(cnt3)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference model state: pending set, pointer, output slot, overflow, count
    typedef struct {
        int          n;
        logic [15:0] pend;
        int          rr;
        bit          vld;
        int          idx;
        bit          ovf;
        int          cnt;
    } mst_t;

    mst_t m4 = '{n:4, pend:16'd0, rr:0, vld:1'b0, idx:0, ovf:1'b0, cnt:0};
    mst_t m3 = '{n:3, pend:16'd0, rr:0, vld:1'b0, idx:0, ovf:1'b0, cnt:0};

    function automatic mst_t step(input mst_t s, input logic [15:0] pulse,
                                  input bit rdy, input bit clr, input bit rs);
        mst_t r;
        int   g;
        int   nc;
        bit   p, q;
        r  = s;
        g  = -1;
        nc = 0;
        if (rs) begin
            r.pend = '0; r.rr = 0; r.vld = 0; r.idx = 0; r.ovf = 0; r.cnt = 0;
            return r;
        end
        if (!s.vld || rdy) begin
            if (s.pend != 0) begin
                for (int k = 0; k < s.n; k++) begin
                    int j;
                    j = (s.rr + k) % s.n;
                    if (g < 0 && ((s.pend >> j) & 16'd1) != 0) g = j;
                end
                r.vld = 1;
                r.idx = g;
                r.rr  = (g + 1) % s.n;
            end else begin
                r.vld = 0;
            end
        end
        r.pend = '0;
        for (int i = 0; i < s.n; i++) begin
            p = ((pulse >> i) & 16'd1) != 0;
            q = ((s.pend >> i) & 16'd1) != 0;
            if (p && q && i != g) nc++;
            if (p || (q && i != g)) r.pend = r.pend | (16'd1 << i);
        end
        r.ovf = (nc > 0) ? 1'b1 : (clr ? 1'b0 : s.ovf);
        r.cnt = clr ? nc : s.cnt + nc;
        if (r.cnt > 255) r.cnt = 255;
        return r;
    endfunction

    // one clock: advance both models with the applied inputs, then compare
    task automatic tick();
        @(posedge clk);
        m4 = step(m4, {12'd0, pulse4}, rdy4, clr4, rst4);
        m3 = step(m3, {13'd0, pulse3}, rdy3, clr3, rst3);
        @(negedge clk);
        chk("m4_valid", int'(v4), int'(m4.vld));
        chk("m4_idx", int'(idx4), m4.idx);
        chk("m4_pend", int'(pend4), int'(m4.pend));
        chk("m4_ovf", int'(ovf4), int'(m4.ovf));
        chk("m3_valid", int'(v3), int'(m3.vld));
        chk("m3_idx", int'(idx3), m3.idx);
        chk("m3_pend", int'(pend3), int'(m3.pend));
        chk("m3_ovf", int'(ovf3), int'(m3.ovf));
`ifdef BTN_ARB_OVF_CNT_EN
        chk("m4_cnt", int'(cnt4), m4.cnt);
        chk("m3_cnt", int'(cnt3), m3.cnt);
`endif
    endtask

    initial begin
        @(negedge clk);
        tick(); tick();
        chk("rst_valid", int'(v4), 0);
        chk("rst_idx", int'(idx4), 0);
        chk("rst_pend", int'(pend4), 0);
        chk("rst_ovf", int'(ovf4), 0);
        rst4 = 0; rst3 = 0;

        // single press: visible two edges after the pulse, for one cycle
        pulse4 = 4'b0100; tick();
        chk("t1_early", int'(v4), 0);
        pulse4 = 4'b0000; tick();
        chk("t1_valid", int'(v4), 1);
        chk("t1_idx", int'(idx4), 2);
        chk("t1_pend", int'(pend4), 0);
        tick();
        chk("t1_done", int'(v4), 0);

        // multi-bit pulse from rr_ptr=0 drains in index order
        rst4 = 1; tick(); rst4 = 0;
        pulse4 = 4'b1011; tick();
        pulse4 = 4'b0000; tick();
        chk("t2_idx0", int'(idx4), 0);
        tick();
        chk("t2_idx1", int'(idx4), 1);
        tick();
        chk("t2_idx3", int'(idx4), 3);
        chk("t2_v3", int'(v4), 1);
        tick();
        chk("t2_empty", int'(v4), 0);

        // stalled consumer: held event, queued press, then coalesced press
        rdy4 = 0;
        pulse4 = 4'b0010; tick();
        pulse4 = 4'b0000; tick();
        chk("t3_idx", int'(idx4), 1);
        tick();
        pulse4 = 4'b0010; tick();
        chk("t3_queued", int'(pend4), 4'b0010);
        chk("t3_noovf", int'(ovf4), 0);
        pulse4 = 4'b0000; tick();
        pulse4 = 4'b0010; tick();
        pulse4 = 4'b0000;
        chk("t3_ovf", int'(ovf4), 1);
        chk("t3_hold_v", int'(v4), 1);
        chk("t3_hold_idx", int'(idx4), 1);
`ifdef BTN_ARB_OVF_CNT_EN
        chk("t3_cnt", int'(cnt4), 1);
`endif

        // clear coincident with a new overflow: set wins; clear alone clears
        clr4 = 1; pulse4 = 4'b0010; tick();
        chk("t5_setwins", int'(ovf4), 1);
`ifdef BTN_ARB_OVF_CNT_EN
        chk("t5_cnt_clrinc", int'(cnt4), 1);
`endif
        pulse4 = 4'b0000; tick();
        chk("t5_cleared", int'(ovf4), 0);
        clr4 = 0; rdy4 = 1;
        tick(); tick(); tick();

        // fairness: btn0 and btn3 re-pressed as soon as each is served
        rst4 = 1; tick(); rst4 = 0;
        for (int c = 0; c < 9; c++) begin
            pulse4 = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            tick();
            if (c >= 1) begin
                chk("t4_valid", int'(v4), 1);
                chk("t4_idx", int'(idx4), (c % 2 == 1) ? 0 : 3);
                chk("t4_noovf", int'(ovf4), 0);
            end
        end
        pulse4 = 4'b0000; tick(); tick(); tick();

        // 3-button instance: reset during a stall discards everything
        rdy3 = 0;
        rst3 = 1; tick(); rst3 = 0;
        pulse3 = 3'b001; tick();
        pulse3 = 3'b110; tick();
        chk("t6_v", int'(v3), 1);
        chk("t6_idx", int'(idx3), 0);
        chk("t6_pend", int'(pend3), 3'b110);
        pulse3 = 3'b000; tick();
        rst3 = 1; tick(); rst3 = 0;
        chk("t6_rst_v", int'(v3), 0);
        chk("t6_rst_idx", int'(idx3), 0);
        chk("t6_rst_pend", int'(pend3), 0);
        chk("t6_rst_ovf", int'(ovf3), 0);
        rdy3 = 1;
        pulse3 = 3'b101; tick();
        chk("t6_nostale", int'(v3), 0);
        pulse3 = 3'b000; tick();
        chk("t6_first0", int'(idx3), 0);
        tick();
        chk("t6_then2", int'(idx3), 2);
        tick();
        chk("t6_idle", int'(v3), 0);
        pulse3 = 3'b011; tick();
        pulse3 = 3'b000; tick();
        chk("t6_wrap0", int'(idx3), 0);
        tick();
        chk("t6_wrap1", int'(idx3), 1);
        tick();

        // long stall with every button hammered: counter saturates
        rdy4 = 0; pulse4 = 4'b1111;
        for (int c = 0; c < 75; c++) tick();
        chk("sat_ovf", int'(ovf4), 1);
`ifdef BTN_ARB_OVF_CNT_EN
        chk("sat_cnt", int'(cnt4), 255);
`endif
        pulse4 = 4'b0000; clr4 = 1; tick();
        chk("sat_clr", int'(ovf4), 0);
        clr4 = 0; rdy4 = 1;
        for (int c = 0; c < 6; c++) tick();

        // randomized traffic on both instances
        for (int c = 0; c < 600; c++) begin
            pulse4 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            pulse3 = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            rdy4   = ($urandom_range(0, 3) != 0);
            rdy3   = ($urandom_range(0, 2) != 0);
            clr4   = ($urandom_range(0, 15) == 0);
            clr3   = ($urandom_range(0, 15) == 0);
            rst4   = ($urandom_range(0, 199) == 0);
            rst3   = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
